// File: rtl/serial_alu_seq_if.sv
// Host-side bundle for serial_alu_seq: operand/opcode request in,
// busy/done status and assembled result/carry out.
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;

    // Requester side: issues operations and watches completion
    modport master (
        output start, op, opa, opb,
        input  busy, done, result, carry
    );

    // Sequencer side: accepts operations and reports results
    modport slave (
        input  start, op, opa, opb,
        output busy, done, result, carry
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial sequencer for the 1-bit ALU slice. Operands are latched on an
// accepted start and fed to the slice LSB first, one bit pair per clock.
// The slice carry is threaded through a local carry register, and the sum
// bits are shifted into the result from the top so that after WIDTH cycles
// the result is aligned.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    serial_alu_seq_if.slave    bus,
    output logic [2:0]         alu_oper,
    output logic               alu_a,
    output logic               alu_b,
    output logic               alu_c_in,
    input  logic               alu_sum,
    input  logic               alu_c_out
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] opa_q,    opa_d;
    logic [WIDTH-1:0] opb_q,    opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [2:0]       oper_q,   oper_d;
    logic             cin_q,    cin_d;
    logic             carry_q,  carry_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Next-state logic. Operand registers shift in zeros, so they are empty
    // again by the time DONE is reached and the slice inputs read as 0 outside
    // SHIFT without extra gating. The carry register is cleared on the last
    // bit for the same reason.
    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        count_d  = count_q;
        oper_d   = oper_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.opa;
                    opb_d   = bus.opb;
                    oper_d  = bus.op;
                    count_d = '0;
                    cin_d   = (bus.op == 3'b001);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                result_d = {alu_sum, result_q[WIDTH-1:1]};
                opa_d    = opa_q >> 1;
                opb_d    = opb_q >> 1;
                count_d  = count_q + CW'(1);
                case (oper_q)
                    3'b000, 3'b001: cin_d = alu_c_out;
                    3'b010:         cin_d = ~alu_c_out;
                    default:        cin_d = 1'b0;
                endcase
                if (count_q == LAST_BIT) begin
                    carry_d = (oper_q <= 3'b010) ? alu_c_out : 1'b0;
                    cin_d   = 1'b0;
                    count_d = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            count_q  <= '0;
            oper_q   <= 3'b000;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            count_q  <= count_d;
            oper_q   <= oper_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.carry  = carry_q;

    assign alu_oper = oper_q;
    assign alu_a    = opa_q[0];
    assign alu_b    = opb_q[0];
    assign alu_c_in = cin_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Testbench for serial_alu_seq: a behavioural 1-bit ALU slice closes the
// loop, a driver issues directed operations and pushes hand-computed
// results into a queue, and a monitor pops and compares on every done.
module tb_serial_alu_seq;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] alu_oper;
    logic alu_a, alu_b, alu_c_in;
    logic alu_sum, alu_c_out;

    int checks = 0;
    int errors = 0;
    logic [WIDTH:0] exp_q[$];

    serial_alu_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .alu_oper  (alu_oper),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c_in  (alu_c_in),
        .alu_sum   (alu_sum),
        .alu_c_out (alu_c_out)
    );

    always #5 clk = ~clk;

    // Reference 1-bit slice: subtracts by inverting an operand, and for
    // reverse subtract the incoming carry is inverted inside the slice
    always_comb begin
        logic fa, fb, fc;
        fa = alu_a;
        fb = alu_b;
        fc = alu_c_in;
        alu_sum   = 1'b0;
        alu_c_out = 1'b0;
        case (alu_oper)
            3'b000, 3'b001, 3'b010: begin
                if (alu_oper == 3'b001) fb = ~alu_b;
                if (alu_oper == 3'b010) begin
                    fa = ~alu_a;
                    fc = ~alu_c_in;
                end
                alu_sum   = fa ^ fb ^ fc;
                alu_c_out = (fa & fb) | (fa & fc) | (fb & fc);
            end
            3'b011: alu_sum = alu_a | alu_b;
            3'b100: alu_sum = alu_a & alu_b;
            3'b101: alu_sum = ~alu_a & alu_b;
            3'b110: alu_sum = alu_a ^ alu_b;
            default: alu_sum = ~(alu_a ^ alu_b);
        endcase
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending operation (result=0x%0h)", bus.result);
            end else begin
                logic [WIDTH:0] e;
                e = exp_q.pop_front();
                check_output("result", 32'(bus.result), 32'(e[WIDTH-1:0]));
                check_output("carry", 32'(bus.carry), 32'(e[WIDTH]));
                check_output("slice_inputs_idle", {29'd0, alu_a, alu_b, alu_c_in}, 32'd0);
            end
        end
    end

    // Waits (bounded) for a done pulse, counting busy cycles on the way
    task automatic wait_done(input string name, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (bus.done) seen = 1'b1;
            else begin
                if (bus.busy) busy_cycles++;
                @(negedge clk);
            end
        end
        check_output({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Issues one operation and pushes its hand-computed result
    task automatic apply_stimulus(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] er,
                                  input logic ec, input string name);
        int bc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
        exp_q.push_back({ec, er});
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(name, bc);
        check_output({name, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
    endtask

    initial begin
        int bc;
        int gap;
        bit dropped;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.opa   = '0;
        bus.opb   = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: everything quiet
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("idle_busy", 32'(bus.busy), 32'd0);
            check_output("idle_done", 32'(bus.done), 32'd0);
            check_output("idle_result", 32'(bus.result), 32'd0);
            check_output("idle_carry", 32'(bus.carry), 32'd0);
            check_output("idle_slice_in", {28'd0, alu_a, alu_b, alu_c_in, 1'b0}, 32'd0);
            check_output("idle_oper", 32'(alu_oper), 32'd0);
        end

        // Arithmetic
        apply_stimulus(3'b000, 8'hC8, 8'h64, 8'h2C, 1'b1, "add");
        apply_stimulus(3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, "sub_borrow");
        apply_stimulus(3'b001, 8'h07, 8'h05, 8'h02, 1'b1, "sub");
        apply_stimulus(3'b010, 8'h03, 8'h10, 8'h0D, 1'b1, "rsub");
        check_output("oper_held", 32'(alu_oper), 32'd2);

        // Logic sweep
        apply_stimulus(3'b011, 8'hAA, 8'h0F, 8'hAF, 1'b0, "or");
        apply_stimulus(3'b100, 8'hAA, 8'h0F, 8'h0A, 1'b0, "and");
        apply_stimulus(3'b101, 8'hAA, 8'h0F, 8'h05, 1'b0, "andn");
        apply_stimulus(3'b110, 8'hAA, 8'h0F, 8'hA5, 1'b0, "xor");
        apply_stimulus(3'b111, 8'hAA, 8'h0F, 8'h5A, 1'b0, "xnor");

        // Start pulsed in the third SHIFT cycle is ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.opa = 8'h01; bus.opb = 8'h02;
        exp_q.push_back({1'b0, 8'h03});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.opa = 8'hFF; bus.opb = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("start_in_shift", bc);
        repeat (14) @(negedge clk);
        check_output("start_in_shift_idle", 32'(bus.busy), 32'd0);

        // Start held across DONE: second operation only from IDLE
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b110; bus.opa = 8'hF0; bus.opb = 8'h3C;
        exp_q.push_back({1'b0, 8'hCC});
        exp_q.push_back({1'b0, 8'hCC});
        @(negedge clk);
        wait_done("held_first", bc);
        gap = 0;
        dropped = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            gap++;
            if (bus.busy && !dropped) begin
                bus.start = 1'b0;
                dropped = 1'b1;
            end
            if (bus.done) break;
        end
        bus.start = 1'b0;
        check_output("held_done_gap", 32'(gap), 32'(WIDTH + 2));

        // Reset in the fourth SHIFT cycle aborts without a done
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b000; bus.opa = 8'h11; bus.opb = 8'h22;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_output("pre_reset_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("abort_busy", 32'(bus.busy), 32'd0);
        check_output("abort_done", 32'(bus.done), 32'd0);
        check_output("abort_result", 32'(bus.result), 32'd0);
        check_output("abort_slice", {28'd0, alu_oper, alu_c_in}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        apply_stimulus(3'b000, 8'h11, 8'h22, 8'h33, 1'b0, "after_reset");

        repeat (3) @(negedge clk);
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a hung design
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
